// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types, widths and the byte-merge helper for dm_wait_mem
package dm_pkg;

    localparam int BYTEEN_W = 4;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dm_state_e;

    // Byte lane k comes from wdata when its enable is set, otherwise from the stored word
    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0]   old_word,
        input logic [WORD_W-1:0]   wdata,
        input logic [BYTEEN_W-1:0] byteen
    );
        logic [WORD_W-1:0] merged;
        for (int k = 0; k < BYTEEN_W; k++) begin
            merged[8*k +: 8] = byteen[k] ? wdata[8*k +: 8] : old_word[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_wait_mem_if.sv
// rtl/dm_wait_mem_if.sv - request/response/commit bundle between the CPU M-stage and dm_wait_mem
interface dm_wait_mem_if;
    import dm_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [BYTEEN_W-1:0] req_byteen;
    logic [WORD_W-1:0]   req_addr;
    logic [WORD_W-1:0]   req_wdata;
    logic [WORD_W-1:0]   req_pc;
    logic                resp_valid;
    logic [WORD_W-1:0]   resp_rdata;
    logic                resp_err;
    logic                commit_valid;
    logic [WORD_W-1:0]   commit_addr;
    logic [WORD_W-1:0]   commit_data;
    logic [WORD_W-1:0]   commit_pc;
    logic                init_done;

    modport master (
        output req_valid, req_byteen, req_addr, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  commit_valid, commit_addr, commit_data, commit_pc, init_done
    );

    modport slave (
        input  req_valid, req_byteen, req_addr, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output commit_valid, commit_addr, commit_data, commit_pc, init_done
    );

endinterface

// File: rtl/dm_wait_ctrl.sv
// rtl/dm_wait_ctrl.sv - CLEAR/IDLE/WAIT/RESP sequencer with clear and wait-state counters
module dm_wait_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    output logic                     o_accept,
    output logic                     o_enter_resp,
    output logic                     o_clr_we,
    output logic [$clog2(DEPTH)-1:0] o_clr_idx,
    output logic                     o_init_done
);

    localparam int         AW      = $clog2(DEPTH);
    localparam bit         NO_WAIT = (LATENCY == 0);
    localparam logic [3:0] LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dm_state_e     r_state;
    dm_state_e     w_next;
    logic [AW-1:0] r_clr_cnt;
    logic [3:0]    r_wait_cnt;
    logic          r_init_done;

    // State register; any reset restarts the clear walk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == AW'(DEPTH - 1)) w_next = ST_IDLE;
            ST_IDLE:  if (i_req_valid) w_next = NO_WAIT ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (r_wait_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_CLEAR;
        endcase
    end

    // Clear word counter, wait down-counter and sticky init flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt   <= '0;
            r_wait_cnt  <= 4'd0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (r_state == ST_IDLE && i_req_valid) begin
                r_wait_cnt <= LAT_M1;
            end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (r_state == ST_CLEAR && w_next == ST_IDLE) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_accept     = (r_state == ST_IDLE) && i_req_valid;
    assign o_enter_resp = (w_next == ST_RESP);
    assign o_clr_we     = (r_state == ST_CLEAR);
    assign o_clr_idx    = r_clr_cnt;
    assign o_init_done  = r_init_done;

endmodule

// File: rtl/dm_wait_mem.sv
// rtl/dm_wait_mem.sv - wait-state data memory with byte merge, range check and write commit trace
module dm_wait_mem
    import dm_pkg::*;
#(
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    dm_wait_mem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic                w_accept;
    logic                w_enter_resp;
    logic                w_clr_we;
    logic [AW-1:0]       w_clr_idx;
    logic                w_req_ready;
    logic                w_init_done;

    logic [BYTEEN_W-1:0] r_byteen;
    logic [WORD_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_pc;

    logic [BYTEEN_W-1:0] w_src_byteen;
    logic [WORD_W-1:0]   w_src_addr;
    logic [WORD_W-1:0]   w_src_wdata;
    logic [WORD_W-1:0]   w_src_pc;
    logic [WORD_W-1:0]   w_offset;
    logic                w_in_range;
    logic [AW-1:0]       w_idx;
    logic [WORD_W-1:0]   w_old;
    logic [WORD_W-1:0]   w_merged;

    logic [WORD_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_idx;
    logic                r_resp_valid;
    logic [WORD_W-1:0]   r_resp_rdata;
    logic                r_resp_err;
    logic                r_commit_valid;
    logic [WORD_W-1:0]   r_commit_addr;
    logic [WORD_W-1:0]   r_commit_data;
    logic [WORD_W-1:0]   r_commit_pc;

    dm_wait_ctrl #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_ctrl (
        .clk          (clk),
        .rst          (reset),
        .i_req_valid  (bus.req_valid),
        .o_req_ready  (w_req_ready),
        .o_accept     (w_accept),
        .o_enter_resp (w_enter_resp),
        .o_clr_we     (w_clr_we),
        .o_clr_idx    (w_clr_idx),
        .o_init_done  (w_init_done)
    );

    // Hold the accepted request so the bus is free to change during WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byteen <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_pc     <= '0;
        end else if (w_accept) begin
            r_byteen <= bus.req_byteen;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_pc     <= bus.req_pc;
        end
    end

    // With zero wait states RESP is entered on the accept edge, so the live bus feeds decode
    assign w_src_byteen = w_accept ? bus.req_byteen : r_byteen;
    assign w_src_addr   = w_accept ? bus.req_addr   : r_addr;
    assign w_src_wdata  = w_accept ? bus.req_wdata  : r_wdata;
    assign w_src_pc     = w_accept ? bus.req_pc     : r_pc;

    // Unsigned 32-bit decode: below BASE never wraps into range
    assign w_offset   = w_src_addr - BASE;
    assign w_in_range = (w_src_addr >= BASE) && ((w_offset >> 2) < 32'(DEPTH));
    assign w_idx      = w_offset[AW+1:2];
    assign w_old      = r_mem[w_idx];
    assign w_merged   = byte_merge(w_old, w_src_wdata, w_src_byteen);

    // Single write port: clear walk during CLEAR, committed write at the edge ending RESP
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (r_commit_valid) begin
            r_mem[r_idx] <= r_commit_data;
        end
    end

    // Response and commit registers, loaded on entry into RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx          <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_err     <= 1'b0;
            r_commit_valid <= 1'b0;
            r_commit_addr  <= '0;
            r_commit_data  <= '0;
            r_commit_pc    <= '0;
        end else begin
            r_resp_valid   <= w_enter_resp;
            r_commit_valid <= w_enter_resp && w_in_range && (w_src_byteen != '0);
            if (w_enter_resp) begin
                r_resp_rdata <= w_in_range ? w_merged : '0;
                r_resp_err   <= !w_in_range;
                r_idx        <= w_idx;
                if (w_in_range && (w_src_byteen != '0)) begin
                    r_commit_addr <= BASE + (32'(w_idx) << 2);
                    r_commit_data <= w_merged;
                    r_commit_pc   <= w_src_pc;
                end
            end
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_rdata   = r_resp_rdata;
    assign bus.resp_err     = r_resp_err;
    assign bus.commit_valid = r_commit_valid;
    assign bus.commit_addr  = r_commit_addr;
    assign bus.commit_data  = r_commit_data;
    assign bus.commit_pc    = r_commit_pc;
    assign bus.init_done    = w_init_done;

endmodule

// File: tb/tb_dm_wait_mem.sv
// tb/tb_dm_wait_mem.sv - directed self-checking bench for dm_wait_mem
module tb_dm_wait_mem;

    localparam int          NDUT   = 4;
    localparam logic [15:0] LAT_PK = {4'd15, 4'd1, 4'd0, 4'd2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        d_rst    [NDUT];
    logic        d_valid  [NDUT];
    logic [3:0]  d_byteen [NDUT];
    logic [31:0] d_addr   [NDUT];
    logic [31:0] d_wdata  [NDUT];
    logic [31:0] d_pc     [NDUT];

    logic        w_ready  [NDUT];
    logic        w_rvalid [NDUT];
    logic [31:0] w_rdata  [NDUT];
    logic        w_err    [NDUT];
    logic        w_cvalid [NDUT];
    logic [31:0] w_caddr  [NDUT];
    logic [31:0] w_cdata  [NDUT];
    logic [31:0] w_cpc    [NDUT];
    logic        w_init   [NDUT];

    int lat_of [NDUT] = '{2, 0, 1, 15};

    int n_checks;
    int n_errors;

    logic [31:0] res_rdata;
    logic        res_err;
    logic        res_cv;
    logic [31:0] res_caddr;
    logic [31:0] res_cdata;
    logic [31:0] res_cpc;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dm_wait_mem_if bus ();
        assign bus.req_valid  = d_valid[g];
        assign bus.req_byteen = d_byteen[g];
        assign bus.req_addr   = d_addr[g];
        assign bus.req_wdata  = d_wdata[g];
        assign bus.req_pc     = d_pc[g];
        assign w_ready[g]     = bus.req_ready;
        assign w_rvalid[g]    = bus.resp_valid;
        assign w_rdata[g]     = bus.resp_rdata;
        assign w_err[g]       = bus.resp_err;
        assign w_cvalid[g]    = bus.commit_valid;
        assign w_caddr[g]     = bus.commit_addr;
        assign w_cdata[g]     = bus.commit_data;
        assign w_cpc[g]       = bus.commit_pc;
        assign w_init[g]      = bus.init_done;

        dm_wait_mem #(
            .DEPTH   (16),
            .LATENCY (int'(LAT_PK[g*4 +: 4])),
            .BASE    ((g == 1) ? 32'h0000_1000 : 32'h0000_0000)
        ) u_dut (
            .clk   (clk),
            .reset (d_rst[g]),
            .bus   (bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait up to a bound for req_ready; returns posedges seen and response pulses seen meanwhile
    task automatic wait_ready(input int k, output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (!w_ready[k] && n < 100) begin
            if (w_rvalid[k] || w_cvalid[k]) pulses++;
            @(negedge clk);
            n++;
        end
    endtask

    // One request: accept, measure latency, capture response, confirm single-cycle pulse
    task automatic xfer(input int k, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc, input string tag);
        int n;
        int p;
        int c;
        logic bad_rdy;
        wait_ready(k, n, p);
        check({tag, "_ready"}, 32'(w_ready[k]), 32'd1);
        d_valid[k]  = 1'b1;
        d_byteen[k] = be;
        d_addr[k]   = addr;
        d_wdata[k]  = wdata;
        d_pc[k]     = pc;
        @(posedge clk);
        @(negedge clk);
        d_valid[k]  = 1'b0;
        d_byteen[k] = ~be;
        d_addr[k]   = ~addr;
        d_wdata[k]  = ~wdata;
        d_pc[k]     = ~pc;
        c = 1;
        bad_rdy = 1'b0;
        while (!w_rvalid[k] && c < 40) begin
            if (w_ready[k]) bad_rdy = 1'b1;
            @(negedge clk);
            c++;
        end
        if (w_ready[k]) bad_rdy = 1'b1;
        check({tag, "_latency"}, 32'(c), 32'(lat_of[k] + 1));
        check({tag, "_ready_low"}, 32'(bad_rdy), 32'd0);
        res_rdata = w_rdata[k];
        res_err   = w_err[k];
        res_cv    = w_cvalid[k];
        res_caddr = w_caddr[k];
        res_cdata = w_cdata[k];
        res_cpc   = w_cpc[k];
        @(negedge clk);
        check({tag, "_pulse"}, {30'd0, w_rvalid[k], w_cvalid[k]}, 32'd0);
        check({tag, "_idle_again"}, 32'(w_ready[k]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p;
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < NDUT; k++) begin
            d_rst[k]    = 1'b1;
            d_valid[k]  = 1'b0;
            d_byteen[k] = 4'h0;
            d_addr[k]   = 32'h0;
            d_wdata[k]  = 32'h0;
            d_pc[k]     = 32'h0;
        end
        repeat (3) @(negedge clk);

        check("rst_ready",  32'(w_ready[0]),  32'd0);
        check("rst_rvalid", 32'(w_rvalid[0]), 32'd0);
        check("rst_rdata",  w_rdata[0],       32'd0);
        check("rst_err",    32'(w_err[0]),    32'd0);
        check("rst_commit", {29'd0, w_cvalid[0], 2'b00} | w_caddr[0] | w_cdata[0] | w_cpc[0], 32'd0);
        check("rst_init",   32'(w_init[0]),   32'd0);

        for (int k = 0; k < NDUT; k++) d_rst[k] = 1'b0;
        n = 0;
        p = 0;
        while (!w_ready[0] && n < 100) begin
            if (w_init[0]) p++;
            @(negedge clk);
            n++;
        end
        check("clear_cycles", 32'(n), 32'd16);
        check("clear_init_early", 32'(p), 32'd0);
        check("clear_init_done", 32'(w_init[0]), 32'd1);

        xfer(0, 4'h0, 32'h3C, 32'h0, 32'h0, "rd_3c");
        check("rd_3c_data", res_rdata, 32'h0);
        check("rd_3c_err", 32'(res_err), 32'd0);

        xfer(0, 4'hF, 32'h8, 32'h1122_3344, 32'h100, "wr_full");
        check("wr_full_cv", 32'(res_cv), 32'd1);
        check("wr_full_cdata", res_cdata, 32'h1122_3344);
        check("wr_full_caddr", res_caddr, 32'h8);

        xfer(0, 4'b0101, 32'h8, 32'hAABB_CCDD, 32'h104, "wr_merge");
        check("wr_merge_cdata", res_cdata, 32'h11BB_33DD);
        check("wr_merge_rdata", res_rdata, 32'h11BB_33DD);

        xfer(0, 4'h0, 32'h8, 32'h0, 32'h108, "rd_merge");
        check("rd_merge_data", res_rdata, 32'h11BB_33DD);
        check("rd_merge_cv", 32'(res_cv), 32'd0);

        xfer(0, 4'hF, 32'h7, 32'h0000_0055, 32'h3010, "trace");
        check("trace_cpc", res_cpc, 32'h3010);
        check("trace_caddr", res_caddr, 32'h4);

        wait_ready(0, n, p);
        d_valid[0]  = 1'b1;
        d_byteen[0] = 4'hF;
        d_addr[0]   = 32'h4;
        d_wdata[0]  = 32'hDEAD_BEEF;
        d_pc[0]     = 32'h200;
        @(posedge clk);
        @(negedge clk);
        d_valid[0] = 1'b0;
        d_rst[0]   = 1'b1;
        #1;
        check("midrst_out", {29'd0, w_rvalid[0], w_cvalid[0], w_init[0]}, 32'd0);
        @(negedge clk);
        d_rst[0] = 1'b0;
        wait_ready(0, n, p);
        check("midrst_clear_cycles", 32'(n), 32'd16);
        check("midrst_no_resp", 32'(p), 32'd0);
        xfer(0, 4'h0, 32'h4, 32'h0, 32'h0, "midrst_rd");
        check("midrst_rd_data", res_rdata, 32'h0);

        xfer(1, 4'hF, 32'h1040, 32'hFFFF_FFFF, 32'h300, "oor_wr");
        check("oor_wr_err", 32'(res_err), 32'd1);
        check("oor_wr_cv", 32'(res_cv), 32'd0);
        check("oor_wr_rdata", res_rdata, 32'h0);
        xfer(1, 4'h0, 32'h1000, 32'h0, 32'h0, "rd_w0");
        check("rd_w0_data", res_rdata, 32'h0);
        check("rd_w0_err", 32'(res_err), 32'd0);
        xfer(1, 4'h0, 32'h0FFC, 32'h0, 32'h0, "oor_rd");
        check("oor_rd_err", 32'(res_err), 32'd1);
        check("oor_rd_rdata", res_rdata, 32'h0);
        xfer(1, 4'hF, 32'h103C, 32'hCAFE_F00D, 32'h304, "wr_w15");
        check("wr_w15_cv", 32'(res_cv), 32'd1);
        check("wr_w15_caddr", res_caddr, 32'h103C);
        xfer(1, 4'h0, 32'h103F, 32'h0, 32'h0, "rd_w15");
        check("rd_w15_data", res_rdata, 32'hCAFE_F00D);
        check("rd_w15_err", 32'(res_err), 32'd0);

        xfer(2, 4'b1000, 32'h0, 32'hAB00_0000, 32'h400, "l1_wr");
        check("l1_wr_cdata", res_cdata, 32'hAB00_0000);
        xfer(2, 4'h0, 32'h0, 32'h0, 32'h0, "l1_rd");
        check("l1_rd_data", res_rdata, 32'hAB00_0000);

        xfer(3, 4'h0, 32'h3C, 32'h0, 32'h0, "l15_rd");
        check("l15_rd_data", res_rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_wait_mem.md
# dm_wait_mem

Parametrised, synthesizable data-memory model for the pipelined MIPS CPU's data-memory port. It replaces the ideal zero-wait array with:
- byte-enable write merging;
- programmable wait states over a valid/ready handshake;
- out-of-range error reporting;
- a self-clearing sequence after reset.

It sits between the CPU's M-stage data interface and the testbench. It emits one commit record per completed write, so trace logging no longer lives in the bench.

## Interface
- DEPTH, 4096, number of 32-bit words; power of two, ≥ 4
- LATENCY, 1, wait cycles between accept and response; 0..15
- BASE, 32'h0000_0000, byte address of word 0; word-aligned
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_byteen  in  4  byte enables; 4'b0000 = read, any non-zero value = write
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  write data, byte lanes aligned to the enables
- req_pc  in  32  address of the issuing instruction, used for trace
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read: stored word; write: merged word that will be stored
- resp_err  out  1  address out of range
- commit_valid  out  1  a write is retiring this cycle
- commit_addr  out  32  word-aligned byte address of the retiring write
- commit_data  out  32  merged word being written
- commit_pc  out  32  req_pc of the retiring write
- init_done  out  1  clear sequence finished

## Operation
- **States:** CLEAR, IDLE, WAIT, RESP.
- **CLEAR** (entered on reset):
  - A word counter walks 0..DEPTH-1 and writes 0 to one word per cycle.
  - req_ready=0 throughout.
  - After word DEPTH-1 is written: go to IDLE and set init_done=1. init_done stays 1 until the next reset.
- **IDLE:**
  - req_ready=1.
  - When req_valid is high, the request is accepted: byteen, addr, wdata and pc are latched.
  - Next state: WAIT if LATENCY>0, otherwise RESP.
- **Address decode:**
  - idx = (addr − BASE) >> 2.
  - In range iff addr ≥ BASE and idx < DEPTH; the comparison uses full 32-bit unsigned arithmetic.
- **WAIT:** a down-counter loaded with LATENCY−1 at accept. When it reaches 0, go to RESP.
- **Entry into RESP** loads the response registers:
  - In range: old = mem[idx] (synchronous read); merged byte k = byteen[k] ? wdata byte k : old byte k.
  - resp_rdata = merged. For a read the enables are all 0, so merged equals old.
  - resp_err = 0 when in range.
  - Out of range: resp_rdata=0, resp_err=1, no write.
- **RESP:**
  - resp_valid=1 for exactly one cycle.
  - If the request is an in-range write: commit_valid=1 with commit_addr = BASE + (idx << 2), commit_data = merged, commit_pc = pc.
  - mem[idx] is written with merged at the edge that ends RESP.
  - Next state is IDLE.
- **Outstanding requests:** one at most; there is no pipelining.
- **Out-of-range write:** commit_valid stays 0.

## Timing
- **Reset values:**
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, commit_valid=0, commit_addr=0, commit_data=0, commit_pc=0, init_done=0.
  - State is CLEAR and the clear counter is 0.
- After reset deasserts, CLEAR lasts DEPTH cycles. req_ready first rises in cycle DEPTH.
- Accept at cycle T (req_valid & req_ready) → resp_valid high in cycle T+1+LATENCY only.
- The block returns to IDLE in cycle T+2+LATENCY.
- Throughput is one request per LATENCY+2 cycles.
- A write is visible to a read accepted at or after T+2+LATENCY.
- resp_valid and commit_valid are single-cycle pulses; there is no back-pressure on responses.
- Request inputs are sampled only in the accept cycle. They may change at any other time.
- **Reset mid-operation** (any state, including mid-CLEAR):
  - All outputs return to their reset values asynchronously.
  - The pending request is discarded and never written.
  - CLEAR restarts from word 0.
- **Address edges:**
  - addr = BASE + 4·DEPTH − 1 is in range (low bits are ignored).
  - addr = BASE + 4·DEPTH is out of range.
  - addr < BASE is out of range, with no wrap-around.

## Structure
- Package dm_pkg:
  - state enum (CLEAR, IDLE, WAIT, RESP);
  - BYTEEN_W=4 and WORD_W=32 constants;
  - function byte_merge(old, wdata, byteen).
- One natural sub-module: dm_wait_ctrl, holding the FSM, clear counter and wait counter. The top level keeps the array, the decode and the output registers.
- The array is a single-port RAM with one read or one write per cycle. CLEAR writes and RESP writes never coincide.

## Test plan
- **Reset and clear** (DEPTH=16): release reset → init_done=0 and req_ready=0 for 16 cycles, then both become 1. A read of 0x3C returns 0 with resp_err=0.
- **Byte merge** (LATENCY=2):
  - Write 0x11223344 with byteen 4'b1111 at 0x8, then write 0xAABBCCDD with byteen 4'b0101 at 0x8.
  - Required: the second commit_data = 0x11BB33DD, and resp_valid appears exactly 3 cycles after each accept.
  - A following read of 0x8 returns 0x11BB33DD.
- **Latency sweep:** LATENCY ∈ {0, 1, 15} → resp_valid arrives at T+1, T+2 and T+16 respectively; req_ready is low from T+1 through the RESP cycle.
- **Range** (DEPTH=16, BASE=0x1000):
  - Write to 0x1040 → resp_err=1, commit_valid=0, memory unchanged.
  - Read of 0x0FFC → resp_err=1, resp_rdata=0.
  - Read of 0x103F → in range, word 15.
- **Reset mid-request:** assert reset in the WAIT cycle of a write of 0xDEADBEEF to 0x4 → no commit and no response. After the new CLEAR, a read of 0x4 returns 0.
- **Trace:** a write issued with req_pc=0x3010 → commit_pc=0x3010 and commit_addr word-aligned when req_addr=0x7.
